// File: rtl/counter_sequencer_pkg.sv
// Shared types and helpers for the counter sequencer: FSM state encoding,
// counter width, default timing parameters and endpoint selection.
package counter_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  localparam int CNT_W        = 4;
  localparam int DEF_PRESCALE = 4;
  localparam int DEF_N_PASSES = 3;

  // The endpoint being approached: Hi while counting up, Lo while counting down.
  function automatic logic [CNT_W-1:0] endpoint_of(input logic             up,
                                                   input logic [CNT_W-1:0] lo,
                                                   input logic [CNT_W-1:0] hi);
    return up ? hi : lo;
  endfunction

endpackage

// File: rtl/counter_sequencer_edge_detect.sv
// One-bit rising-edge pulser. The armed flag suppresses a false edge on the
// first cycle after reset when the input is already high.
module edge_detect (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_level,
  output logic o_rise
);

  logic r_prev;
  logic r_armed;

  // Input history and post-reset arming flag.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_prev  <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_prev  <= i_level;
      r_armed <= 1'b1;
    end
  end

  assign o_rise = i_level & ~r_prev & r_armed;

endmodule

// File: rtl/counter_sequencer.sv
// Sequencer driving a 4-bit loadable up/down counter through a [Lo,Hi] window
// at a prescaled tick rate, with wrap/bounce modes, pause/resume and a pass limit.
module counter_sequencer
  import counter_sequencer_pkg::*;
#(
  parameter int PRESCALE = DEF_PRESCALE,
  parameter int N_PASSES = DEF_N_PASSES
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic             i_bounce,
  input  logic             i_dir_init,
  input  logic [CNT_W-1:0] i_lo_limit,
  input  logic [CNT_W-1:0] i_hi_limit,
  input  logic [CNT_W-1:0] i_count_val,
  output logic             o_load,
  output logic [CNT_W-1:0] o_count_in,
  output logic             o_count_en,
  output logic             o_up,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_cfg_err
);

  localparam int PS_W = $clog2(PRESCALE);
  localparam int PC_W = $clog2(N_PASSES + 1);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
  localparam logic [PC_W-1:0] PC_LAST = PC_W'(N_PASSES);

  logic w_start_rise;
  logic w_stop_rise;

  state_t           r_state,    w_state_next;
  logic [PS_W-1:0]  r_presc,    w_presc_next;
  logic [PC_W-1:0]  r_pass,     w_pass_next;
  logic [PC_W-1:0]  w_pass_inc;
  logic [CNT_W-1:0] r_lo,       w_lo_next;
  logic [CNT_W-1:0] r_hi,       w_hi_next;
  logic             r_dir,      w_dir_next;
  logic             r_load,     w_load_next;
  logic [CNT_W-1:0] r_count_in, w_count_in_next;
  logic             r_count_en, w_count_en_next;
  logic             r_up,       w_up_next;
  logic             r_busy,     w_busy_next;
  logic             r_done,     w_done_next;
  logic             r_cfg_err,  w_cfg_err_next;

  edge_detect u_start_edge (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_level (i_start),
    .o_rise  (w_start_rise)
  );

  edge_detect u_stop_edge (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_level (i_stop),
    .o_rise  (w_stop_rise)
  );

  // State, counters, latched config and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_presc    <= '0;
      r_pass     <= '0;
      r_lo       <= '0;
      r_hi       <= '0;
      r_dir      <= 1'b0;
      r_load     <= 1'b0;
      r_count_in <= '0;
      r_count_en <= 1'b0;
      r_up       <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_cfg_err  <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_presc    <= w_presc_next;
      r_pass     <= w_pass_next;
      r_lo       <= w_lo_next;
      r_hi       <= w_hi_next;
      r_dir      <= w_dir_next;
      r_load     <= w_load_next;
      r_count_in <= w_count_in_next;
      r_count_en <= w_count_en_next;
      r_up       <= w_up_next;
      r_busy     <= w_busy_next;
      r_done     <= w_done_next;
      r_cfg_err  <= w_cfg_err_next;
    end
  end

  assign w_pass_inc = r_pass + PC_W'(1);

  // Next-state and next-output decode; strobes default low every cycle.
  always_comb begin
    w_state_next    = r_state;
    w_presc_next    = r_presc;
    w_pass_next     = r_pass;
    w_lo_next       = r_lo;
    w_hi_next       = r_hi;
    w_dir_next      = r_dir;
    w_load_next     = 1'b0;
    w_count_in_next = r_count_in;
    w_count_en_next = 1'b0;
    w_up_next       = r_up;
    w_done_next     = 1'b0;
    w_cfg_err_next  = r_cfg_err;

    case (r_state)
      ST_IDLE: begin
        if (w_start_rise && !w_stop_rise) begin
          w_lo_next  = i_lo_limit;
          w_hi_next  = i_hi_limit;
          w_dir_next = i_dir_init;
          if (i_lo_limit > i_hi_limit) begin
            w_cfg_err_next = 1'b1;
          end else begin
            w_cfg_err_next  = 1'b0;
            w_state_next    = ST_LOAD;
            w_load_next     = 1'b1;
            w_count_in_next = i_dir_init ? i_lo_limit : i_hi_limit;
            w_up_next       = i_dir_init;
            w_pass_next     = '0;
          end
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_LOAD: begin
        w_state_next = ST_RUN;
        w_presc_next = '0;
      end
      ST_RUN: begin
        if (w_stop_rise) begin
          w_state_next = ST_HOLD;
        end else if (r_presc == PS_LAST) begin
          w_presc_next = '0;
          if (i_count_val != endpoint_of(r_up, r_lo, r_hi)) begin
            w_count_en_next = 1'b1;
          end else begin
            w_pass_next = w_pass_inc;
            if (i_bounce) begin
              w_up_next = ~r_up;
            end else begin
              w_load_next     = 1'b1;
              w_count_in_next = r_dir ? r_lo : r_hi;
            end
            // The final endpoint event still issues its reload/reversal.
            if (w_pass_inc == PC_LAST) begin
              w_state_next = ST_IDLE;
              w_done_next  = 1'b1;
              w_pass_next  = '0;
            end else begin
              w_state_next = ST_RUN;
            end
          end
        end else begin
          w_presc_next = r_presc + PS_W'(1);
        end
      end
      ST_HOLD: begin
        if (w_stop_rise) begin
          w_state_next = ST_IDLE;
          w_pass_next  = '0;
        end else if (w_start_rise) begin
          w_state_next = ST_RUN;
        end else begin
          w_state_next = ST_HOLD;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase

    w_busy_next = (w_state_next != ST_IDLE);
  end

  assign o_load     = r_load;
  assign o_count_in = r_count_in;
  assign o_count_en = r_count_en;
  assign o_up       = r_up;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_cfg_err  = r_cfg_err;

endmodule

// File: tb/tb_counter_sequencer.sv
// Self-checking bench: sequencer plus a behavioural 4-bit counter in the loop,
// table-driven runs, hand-written pause/abort/reset sequences and random runs.
module tb_counter_sequencer;

  localparam int P = 4;
  localparam int N = 3;

  logic       clk;
  logic       i_reset, i_start, i_stop, i_bounce, i_dir_init;
  logic [3:0] i_lo_limit, i_hi_limit, count_val;
  logic       o_load, o_count_en, o_up, o_busy, o_done, o_cfg_err;
  logic [3:0] o_count_in;

  int n_pass  = 0;
  int n_total = 0;

  counter_sequencer #(.PRESCALE(P), .N_PASSES(N)) dut (
    .i_clk       (clk),
    .i_reset     (i_reset),
    .i_start     (i_start),
    .i_stop      (i_stop),
    .i_bounce    (i_bounce),
    .i_dir_init  (i_dir_init),
    .i_lo_limit  (i_lo_limit),
    .i_hi_limit  (i_hi_limit),
    .i_count_val (count_val),
    .o_load      (o_load),
    .o_count_in  (o_count_in),
    .o_count_en  (o_count_en),
    .o_up        (o_up),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_cfg_err   (o_cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural loadable up/down counter; its nReset is ~Reset.
  always_ff @(posedge clk) begin
    if (i_reset)         count_val <= 4'd0;
    else if (o_load)     count_val <= o_count_in;
    else if (o_count_en) count_val <= o_up ? count_val + 4'd1 : count_val - 4'd1;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full sequence from a Start edge in IDLE. exp_t < 0 means take tick
  // count and final value from the reference model.
  task automatic run_seq(input logic [3:0] lo, input logic [3:0] hi, input logic dir,
                         input logic bnc, input int exp_t, input logic [3:0] exp_final,
                         input string name);
    logic [3:0] vals[$];
    logic [3:0] v, st, fin;
    logic       up;
    int         pass, steps, t, en_cnt, idx;
    bit         overlap, early;
    st = dir ? lo : hi;
    v = st; up = dir; pass = 0; steps = 0;
    vals.push_back(v);
    while (pass < N) begin
      if (v != (up ? hi : lo)) begin
        v = up ? v + 4'd1 : v - 4'd1;
        steps++;
      end else begin
        pass++;
        if (bnc) up = ~up;
        else     v = st;
      end
      vals.push_back(v);
    end
    t   = (exp_t < 0) ? vals.size() - 1 : exp_t;
    fin = (exp_t < 0) ? vals[vals.size()-1] : exp_final;

    i_lo_limit = lo; i_hi_limit = hi; i_dir_init = dir; i_bounce = bnc;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    // limits and direction are sampled only at start
    i_lo_limit = 4'($urandom); i_hi_limit = 4'($urandom); i_dir_init = ~dir;
    chk({name, "_load"},    int'(o_load), 1);
    chk({name, "_countin"}, int'(o_count_in), int'(st));
    chk({name, "_up"},      int'(o_up), int'(dir));
    chk({name, "_busy"},    int'(o_busy), 1);
    en_cnt = 0; overlap = 0; early = 0;
    for (int n = 1; n <= P*t + 2; n++) begin
      tick();
      if (o_load && o_count_en) overlap = 1;
      if (o_count_en) en_cnt++;
      idx = (n - 2) / P;
      if (n >= 2 && (n - 2) % P == 0 && idx < vals.size())
        chk($sformatf("%s_val%0d", name, idx), int'(count_val), int'(vals[idx]));
      if (n == 1 + P*t) chk({name, "_done"}, int'(o_done), 1);
      else if (o_done) early = 1;
    end
    chk({name, "_busy_end"},  int'(o_busy), 0);
    chk({name, "_final"},     int'(count_val), int'(fin));
    chk({name, "_overlap"},   int'(overlap), 0);
    chk({name, "_stray_done"}, int'(early), 0);
    chk({name, "_en_count"},  en_cnt, steps);
  endtask

  typedef struct {
    logic [3:0] lo, hi;
    logic       dir, bnc;
    int         ticks;
    logic [3:0] final_val;
  } vec_t;

  vec_t vecs[5];
  bit   bad;
  int   guard;
  logic [3:0] rlo, rhi, rtmp;

  initial begin
    vecs[0] = '{lo: 4'd2, hi: 4'd5,  dir: 1'b1, bnc: 1'b0, ticks: 12, final_val: 4'd2};
    vecs[1] = '{lo: 4'd2, hi: 4'd5,  dir: 1'b1, bnc: 1'b1, ticks: 12, final_val: 4'd5};
    vecs[2] = '{lo: 4'd7, hi: 4'd7,  dir: 1'b0, bnc: 1'b0, ticks: 3,  final_val: 4'd7};
    vecs[3] = '{lo: 4'd3, hi: 4'd4,  dir: 1'b0, bnc: 1'b0, ticks: 6,  final_val: 4'd4};
    vecs[4] = '{lo: 4'd0, hi: 4'd15, dir: 1'b0, bnc: 1'b1, ticks: 48, final_val: 4'd0};

    i_reset = 1'b1; i_start = 1'b0; i_stop = 1'b0; i_bounce = 1'b0; i_dir_init = 1'b0;
    i_lo_limit = 4'd0; i_hi_limit = 4'd0;
    tick(); tick();
    chk("reset_strobes", int'({o_load, o_count_en, o_up, o_done}), 0);
    chk("reset_busy",    int'(o_busy), 0);
    chk("reset_cfg_err", int'(o_cfg_err), 0);
    chk("reset_countin", int'(o_count_in), 0);
    i_reset = 1'b0;
    tick();

    for (int i = 0; i < 5; i++)
      run_seq(vecs[i].lo, vecs[i].hi, vecs[i].dir, vecs[i].bnc, vecs[i].ticks,
              vecs[i].final_val, $sformatf("vec%0d", i));

    // Lo > Hi: configuration error, nothing starts
    i_lo_limit = 4'd9; i_hi_limit = 4'd3; i_dir_init = 1'b1;
    i_start = 1'b1; tick(); i_start = 1'b0;
    chk("cfg_err_set", int'(o_cfg_err), 1);
    chk("cfg_err_busy", int'(o_busy), 0);
    bad = 0;
    repeat (8) begin
      tick();
      if (o_load || o_busy) bad = 1;
    end
    chk("cfg_err_no_load", int'(bad), 0);
    run_seq(4'd3, 4'd9, 1'b1, 1'b0, -1, 4'd0, "cfg_ok");
    chk("cfg_err_clear", int'(o_cfg_err), 0);

    // Pause at Count_val=4, hold 20 clocks, resume in phase, then abort from HOLD
    i_lo_limit = 4'd2; i_hi_limit = 4'd5; i_dir_init = 1'b1; i_bounce = 1'b0;
    i_start = 1'b1; tick(); i_start = 1'b0;
    repeat (10) tick();
    chk("hold_pre_val", int'(count_val), 4);
    i_stop = 1'b1; tick(); i_stop = 1'b0;
    chk("hold_busy", int'(o_busy), 1);
    bad = 0;
    repeat (20) begin
      tick();
      if (count_val != 4'd4 || o_load || o_count_en) bad = 1;
    end
    chk("hold_frozen", int'(bad), 0);
    i_start = 1'b1; tick(); i_start = 1'b0;
    tick(); tick();
    chk("resume_no_early_en", int'(o_count_en), 0);
    tick();
    chk("resume_phase_en", int'(o_count_en), 1);
    tick();
    chk("resume_val", int'(count_val), 5);
    i_stop = 1'b1; tick(); i_stop = 1'b0;
    tick();
    chk("hold2_busy", int'(o_busy), 1);
    i_stop = 1'b1; tick(); i_stop = 1'b0;
    chk("abort_busy", int'(o_busy), 0);
    bad = 0;
    repeat (10) begin
      if (o_done || o_busy) bad = 1;
      tick();
    end
    chk("abort_no_done", int'(bad), 0);

    // Randomised runs against the reference model
    for (int r = 0; r < 6; r++) begin
      rlo = 4'($urandom_range(0, 15));
      rhi = 4'($urandom_range(0, 15));
      if (rlo > rhi) begin rtmp = rlo; rlo = rhi; rhi = rtmp; end
      run_seq(rlo, rhi, 1'($urandom), 1'($urandom), -1, 4'd0, $sformatf("rnd%0d", r));
    end

    // Reset mid-run with Start held high through release
    i_lo_limit = 4'd2; i_hi_limit = 4'd5; i_dir_init = 1'b1; i_bounce = 1'b0;
    i_start = 1'b1; tick(); i_start = 1'b0;
    repeat (7) tick();
    i_reset = 1'b1; i_start = 1'b1;
    tick();
    chk("midrst_outputs", int'({o_load, o_count_en, o_up, o_busy, o_done, o_cfg_err}), 0);
    chk("midrst_countin", int'(o_count_in), 0);
    tick();
    i_reset = 1'b0;
    bad = 0;
    repeat (4) begin
      tick();
      if (o_load || o_busy) bad = 1;
    end
    chk("held_start_ignored", int'(bad), 0);
    i_start = 1'b0; tick();
    i_start = 1'b1; tick(); i_start = 1'b0;
    chk("restart_load", int'(o_load), 1);
    chk("restart_busy", int'(o_busy), 1);
    guard = 0;
    while (o_busy && guard < 200) begin
      tick();
      guard++;
    end
    chk("restart_completes", int'(o_busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
